// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions for the BCD counter encoder and the display-side reader.
// Segment order is gfedcba in bits 6:0; bit 7 (decimal point) is never part of a digit code.
package seg7_pkg;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_MASK = 7'h7F;

  typedef enum logic {
    EMPTY  = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Encoder table built from the same constants the decoder checks against.
  function automatic logic [6:0] seg7_encode(input logic [3:0] digit);
    case (digit)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return 7'h00;
    endcase
  endfunction

endpackage

// File: rtl/seg7_reader_if.sv
// Segment-bus and status bundle between the counter's display outputs and the seg7_reader.
// master drives the segment patterns and sample enable; slave is the reader.
interface seg7_reader_if;

  logic       CE;
  logic [7:0] seg_lo;
  logic [7:0] seg_hi;
  logic [3:0] digit_lo;
  logic [3:0] digit_hi;
  logic       value_valid;
  logic       update;
  logic       step_err;
  logic       code_err;

  modport master (
    output CE, seg_lo, seg_hi,
    input  digit_lo, digit_hi, value_valid, update, step_err, code_err
  );

  modport slave (
    input  CE, seg_lo, seg_hi,
    output digit_lo, digit_hi, value_valid, update, step_err, code_err
  );

endinterface

// File: rtl/seg7_decode.sv
// Combinational seven-segment to BCD decoder; any code outside the ten digit shapes is illegal.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] code,
  output logic [3:0] digit,
  output logic       legal
);

  always_comb begin
    digit = 4'd0;
    legal = 1'b1;
    case (code & SEG_MASK)
      SEG_0:   digit = 4'd0;
      SEG_1:   digit = 4'd1;
      SEG_2:   digit = 4'd2;
      SEG_3:   digit = 4'd3;
      SEG_4:   digit = 4'd4;
      SEG_5:   digit = 4'd5;
      SEG_6:   digit = 4'd6;
      SEG_7:   digit = 4'd7;
      SEG_8:   digit = 4'd8;
      SEG_9:   digit = 4'd9;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_reader.sv
// Display-side monitor: debounces the two segment buses, decodes stable pairs back to BCD and
// flags illegal shapes and displayed values that do not advance by exactly +1 modulo 100.
module seg7_reader
  import seg7_pkg::*;
#(
  // Legal range 2..15.
  parameter int unsigned STABLE_CYCLES = 4
) (
  input logic          C,
  input logic          CLR,
  seg7_reader_if.slave bus
);

  localparam logic [3:0] CntMax    = 4'(STABLE_CYCLES);
  localparam logic [3:0] AcceptCnt = 4'(STABLE_CYCLES - 1);

  logic [13:0] in_pair;
  logic        unused_dp;
  logic [13:0] cand_q;
  logic [3:0]  cnt_q;
  state_t      state_q;
  logic [3:0]  digit_lo_q, digit_hi_q;
  logic        value_valid_q, update_q, step_err_q, code_err_q;

  logic [3:0]  dec_lo, dec_hi;
  logic        legal_lo, legal_hi;
  logic [3:0]  succ_lo, succ_hi;
  logic        same_pair, accept, is_held, is_succ;

  assign in_pair   = {bus.seg_hi[6:0], bus.seg_lo[6:0]};
  assign unused_dp = ^{bus.seg_hi[7], bus.seg_lo[7]};

  // At an accept the input equals cand, so decoding the live input is equivalent.
  seg7_decode u_dec_lo (
    .code  (in_pair[6:0]),
    .digit (dec_lo),
    .legal (legal_lo)
  );

  seg7_decode u_dec_hi (
    .code  (in_pair[13:7]),
    .digit (dec_hi),
    .legal (legal_hi)
  );

  assign same_pair = (cnt_q != 4'd0) && (in_pair == cand_q);
  // cnt saturates at CntMax, so the accept count is passed exactly once per stable run.
  assign accept    = bus.CE && same_pair && (cnt_q == AcceptCnt);

  always_comb begin
    succ_lo = digit_lo_q + 4'd1;
    succ_hi = digit_hi_q;
    if (digit_lo_q == 4'd9) begin
      succ_lo = 4'd0;
      succ_hi = (digit_hi_q == 4'd9) ? 4'd0 : digit_hi_q + 4'd1;
    end
  end

  assign is_held = (dec_hi == digit_hi_q) && (dec_lo == digit_lo_q);
  assign is_succ = (dec_hi == succ_hi) && (dec_lo == succ_lo);

  always_ff @(posedge C) begin
    if (CLR) begin
      cand_q        <= '0;
      cnt_q         <= '0;
      state_q       <= EMPTY;
      digit_lo_q    <= '0;
      digit_hi_q    <= '0;
      value_valid_q <= 1'b0;
      update_q      <= 1'b0;
      step_err_q    <= 1'b0;
      code_err_q    <= 1'b0;
    end else begin
      update_q <= 1'b0;

      if (bus.CE) begin
        if (same_pair) begin
          if (cnt_q != CntMax) cnt_q <= cnt_q + 4'd1;
        end else begin
          cand_q <= in_pair;
          cnt_q  <= 4'd1;
        end
      end

      if (accept) begin
        if (!(legal_lo && legal_hi)) begin
          code_err_q    <= 1'b1;
          value_valid_q <= 1'b0;
          state_q       <= EMPTY;
        end else if (state_q == EMPTY) begin
          digit_lo_q    <= dec_lo;
          digit_hi_q    <= dec_hi;
          value_valid_q <= 1'b1;
          update_q      <= 1'b1;
          state_q       <= LOCKED;
        end else if (!is_held) begin
          digit_lo_q <= dec_lo;
          digit_hi_q <= dec_hi;
          update_q   <= 1'b1;
          if (!is_succ) step_err_q <= 1'b1;
        end
      end
    end
  end

  assign bus.digit_lo    = digit_lo_q;
  assign bus.digit_hi    = digit_hi_q;
  assign bus.value_valid = value_valid_q;
  assign bus.update      = update_q;
  assign bus.step_err    = step_err_q;
  assign bus.code_err    = code_err_q;

endmodule

// File: tb/tb_seg7_reader.sv
// Bench for seg7_reader: directed scenarios plus random segment traffic, every cycle compared
// against a run-length reference model of the display value.
module tb_seg7_reader;

  localparam int unsigned S = 4;

  logic C = 1'b0;
  logic CLR;

  seg7_reader_if bus ();

  seg7_reader #(.STABLE_CYCLES(S)) dut (
    .C   (C),
    .CLR (CLR),
    .bus (bus)
  );

  always #5 C = ~C;

  int n_vec = 0;
  int n_err = 0;
  int n_upd = 0;

  logic [6:0] codes [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  // Reference model: length of the current run of identical pairs and the displayed value.
  logic [13:0] m_prev = '0;
  int m_run = 0;
  int m_hi = 0, m_lo = 0;
  bit m_valid = 0, m_upd = 0, m_step = 0, m_code = 0;

  function automatic int dec(logic [6:0] c);
    for (int i = 0; i < 10; i++) if (codes[i] == c) return i;
    return -1;
  endfunction

  function automatic logic [7:0] seg8(int d);
    logic [6:0] c;
    c = codes[d];
    return {1'($urandom), c};
  endfunction

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(bit clr, bit ce, logic [7:0] hi, logic [7:0] lo);
    int dh, dl, nv, ov;
    logic [13:0] pat;
    m_upd = 0;
    if (clr) begin
      m_run = 0; m_valid = 0; m_step = 0; m_code = 0; m_hi = 0; m_lo = 0;
      return;
    end
    if (!ce) return;
    pat = {hi[6:0], lo[6:0]};
    if (m_run > 0 && pat == m_prev) m_run++;
    else begin
      m_prev = pat;
      m_run  = 1;
    end
    if (m_run != int'(S)) return;
    dh = dec(hi[6:0]);
    dl = dec(lo[6:0]);
    if (dh < 0 || dl < 0) begin
      m_code  = 1;
      m_valid = 0;
      return;
    end
    nv = dh * 10 + dl;
    ov = m_hi * 10 + m_lo;
    if (!m_valid) begin
      m_valid = 1;
      m_upd   = 1;
    end else if (nv != ov) begin
      if (nv != (ov + 1) % 100) m_step = 1;
      m_upd = 1;
    end
    m_hi = dh;
    m_lo = dl;
  endtask

  task automatic tick(bit clr, bit ce, logic [7:0] hi, logic [7:0] lo);
    CLR        = clr;
    bus.CE     = ce;
    bus.seg_hi = hi;
    bus.seg_lo = lo;
    model_edge(clr, ce, hi, lo);
    @(posedge C);
    #1;
    if (bus.update === 1'b1) n_upd++;
    chk("digit_hi", 8'(bus.digit_hi), 8'(m_hi));
    chk("digit_lo", 8'(bus.digit_lo), 8'(m_lo));
    chk("value_valid", 8'(bus.value_valid), 8'(m_valid));
    chk("update", 8'(bus.update), 8'(m_upd));
    chk("step_err", 8'(bus.step_err), 8'(m_step));
    chk("code_err", 8'(bus.code_err), 8'(m_code));
  endtask

  task automatic show(int v, int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b1, seg8(v / 10), seg8(v % 10));
  endtask

  initial begin
    int base, cur, len;
    logic [7:0] lo_pat;
    bit ce;

    // Reset, CLR dominating CE
    tick(1'b1, 1'b0, 8'h00, 8'h00);
    tick(1'b1, 1'b1, 8'h3F, 8'h06);
    chk("rst_valid", 8'(bus.value_valid), 8'h00);
    chk("rst_flags", 8'({bus.step_err, bus.code_err, bus.update}), 8'h00);

    // First accept on the 4th edge
    base = n_upd;
    show(1, 3);
    chk("early_valid", 8'(bus.value_valid), 8'h00);
    show(1, 1);
    chk("first_upd", 8'(bus.update), 8'h01);
    chk("first_val", 8'({bus.digit_hi, bus.digit_lo}), 8'h01);
    show(1, 2);
    chk("first_one_pulse", 8'(n_upd - base), 8'd1);

    // 08 -> 09 -> 10
    tick(1'b1, 1'b1, 8'h00, 8'h00);
    base = n_upd;
    show(8, 6); show(9, 6); show(10, 6);
    chk("seq_pulses", 8'(n_upd - base), 8'd3);
    chk("seq_val", 8'({bus.digit_hi, bus.digit_lo}), 8'h10);
    chk("seq_step", 8'(bus.step_err), 8'h00);

    // 99 -> 00 wrap
    tick(1'b1, 1'b1, 8'h00, 8'h00);
    base = n_upd;
    show(99, 6); show(0, 6);
    chk("wrap_pulses", 8'(n_upd - base), 8'd2);
    chk("wrap_val", 8'({bus.digit_hi, bus.digit_lo}), 8'h00);
    chk("wrap_step", 8'(bus.step_err), 8'h00);

    // Short glitch is filtered
    tick(1'b1, 1'b1, 8'h00, 8'h00);
    show(5, 6); show(7, 2); show(6, 6);
    chk("glitch_val", 8'({bus.digit_hi, bus.digit_lo}), 8'h06);
    chk("glitch_step", 8'(bus.step_err), 8'h00);

    // A -> B(short) -> A: no pulse
    base = n_upd;
    show(9, 2); show(6, 6);
    chk("reaccept_nopulse", 8'(n_upd - base), 8'd0);

    // Jump sets sticky step_err
    tick(1'b1, 1'b1, 8'h00, 8'h00);
    show(5, 6); show(8, 6);
    chk("jump_val", 8'({bus.digit_hi, bus.digit_lo}), 8'h08);
    chk("jump_step", 8'(bus.step_err), 8'h01);
    show(9, 6); show(10, 6);
    chk("jump_sticky", 8'(bus.step_err), 8'h01);

    // Illegal code, then recovery
    tick(1'b1, 1'b1, 8'h00, 8'h00);
    show(5, 6);
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, 8'h3F, 8'h7C);
    chk("illegal_code", 8'(bus.code_err), 8'h01);
    chk("illegal_valid", 8'(bus.value_valid), 8'h00);
    base = n_upd;
    show(42, 6);
    chk("recover_valid", 8'(bus.value_valid), 8'h01);
    chk("recover_pulse", 8'(n_upd - base), 8'd1);
    chk("recover_val", 8'({bus.digit_hi, bus.digit_lo}), 8'h42);
    chk("recover_step", 8'(bus.step_err), 8'h00);

    // CLR on the 3rd edge of a run discards it
    tick(1'b1, 1'b1, 8'h00, 8'h00);
    show(12, 2);
    tick(1'b1, 1'b1, seg8(1), seg8(2));
    chk("clr_mid_valid", 8'(bus.value_valid), 8'h00);
    show(12, 3);
    chk("clr_restart", 8'(bus.value_valid), 8'h00);
    show(12, 1);
    chk("clr_then_accept", 8'(bus.value_valid), 8'h01);

    // CE gated: accept on the 4th CE-high edge, update lasts one C cycle
    tick(1'b1, 1'b1, 8'h00, 8'h00);
    for (int i = 0; i < 6; i++) tick(1'b0, (i % 2) == 0, seg8(3), seg8(4));
    chk("ce_not_yet", 8'(bus.value_valid), 8'h00);
    tick(1'b0, 1'b1, seg8(3), seg8(4));
    chk("ce_accept", 8'(bus.update), 8'h01);
    tick(1'b0, 1'b0, seg8(3), seg8(4));
    chk("ce_pulse_end", 8'(bus.update), 8'h00);

    // Random traffic, mostly counting upward
    tick(1'b1, 1'b1, 8'h00, 8'h00);
    cur = 0;
    for (int s = 0; s < 150; s++) begin
      if ($urandom_range(0, 3) != 0) cur = (cur + 1) % 100;
      else cur = $urandom_range(0, 99);
      len = $urandom_range(1, 7);
      lo_pat = (($urandom_range(0, 7)) == 0) ? 8'($urandom) : 8'h00;
      for (int k = 0; k < len; k++) begin
        ce = ($urandom_range(0, 3) != 0);
        if (lo_pat != 8'h00) tick($urandom_range(0, 199) == 0, ce, seg8(cur / 10), lo_pat);
        else tick($urandom_range(0, 199) == 0, ce, seg8(cur / 10), seg8(cur % 10));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
